// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences signed multiply/divide requests onto external unsigned datapaths,
// handling sign fix-up, immediate exceptions, aborts and a per-operation timeout.
module multdiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic        mult_start,
    output logic        div_start,
    output logic [31:0] unit_opA,
    output logic [31:0] unit_opB,
    input  logic [31:0] mult_result,
    input  logic        mult_overflow,
    input  logic        mult_ready,
    input  logic [31:0] div_result,
    input  logic        div_ready,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, DONE} state_t;

    state_t      state, state_d;
    logic        pend, pend_d, neg, neg_d, exc_d, mstart_d, dstart_d, timeout;
    logic [5:0]  cnt, cnt_d;
    logic [31:0] opa_d, opb_d, res_d, abs_a, abs_b;

    assign abs_a          = data_operandA[31] ? -data_operandA : data_operandA;
    assign abs_b          = data_operandB[31] ? -data_operandB : data_operandB;
    assign timeout        = cnt == 6'(TIMEOUT - 1);
    assign data_resultRDY = state == DONE;
    // pend marks an immediate-exception request waiting one cycle in IDLE before DONE
    assign busy           = state == MULT_RUN || state == DIV_RUN || pend;

    always_comb begin
        state_d  = state;
        pend_d   = 1'b0;
        neg_d    = neg;
        cnt_d    = cnt + 6'd1;
        opa_d    = unit_opA;
        opb_d    = unit_opB;
        res_d    = data_result;
        exc_d    = data_exception;
        mstart_d = 1'b0;
        dstart_d = 1'b0;
        if (ctrl_MULT || ctrl_DIV) begin
            cnt_d   = 6'd0;
            state_d = IDLE;
            if (ctrl_MULT && ctrl_DIV) begin
                pend_d = 1'b1;
                res_d  = 32'd0;
                exc_d  = 1'b1;
            end else if (ctrl_MULT) begin
                opa_d    = data_operandA;
                opb_d    = data_operandB;
                mstart_d = 1'b1;
                state_d  = MULT_RUN;
            end else if (data_operandB == 32'd0) begin
                pend_d = 1'b1;
                res_d  = 32'd0;
                exc_d  = 1'b1;
            end else if (data_operandA == 32'h8000_0000 && data_operandB == 32'hFFFF_FFFF) begin
                pend_d = 1'b1;
                res_d  = 32'h8000_0000;
                exc_d  = 1'b1;
            end else begin
                opa_d    = abs_a;
                opb_d    = abs_b;
                neg_d    = data_operandA[31] ^ data_operandB[31];
                dstart_d = 1'b1;
                state_d  = DIV_RUN;
            end
        end else begin
            case (state)
                IDLE:     state_d = pend ? DONE : IDLE;
                MULT_RUN: if (mult_ready) begin
                    res_d   = mult_result;
                    exc_d   = mult_overflow;
                    state_d = DONE;
                end else if (timeout) begin
                    res_d   = 32'd0;
                    exc_d   = 1'b1;
                    state_d = DONE;
                end
                DIV_RUN:  if (div_ready) begin
                    res_d   = neg ? -div_result : div_result;
                    exc_d   = 1'b0;
                    state_d = DONE;
                end else if (timeout) begin
                    res_d   = 32'd0;
                    exc_d   = 1'b1;
                    state_d = DONE;
                end
                default:  state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pend           <= 1'b0;
            neg            <= 1'b0;
            cnt            <= 6'd0;
            unit_opA       <= 32'd0;
            unit_opB       <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            mult_start     <= 1'b0;
            div_start      <= 1'b0;
        end else begin
            state          <= state_d;
            pend           <= pend_d;
            neg            <= neg_d;
            cnt            <= cnt_d;
            unit_opA       <= opa_d;
            unit_opB       <= opb_d;
            data_result    <= res_d;
            data_exception <= exc_d;
            mult_start     <= mstart_d;
            div_start      <= dstart_d;
        end
    end
endmodule
